// File: rtl/serdes_pkg.sv
// Shared helpers for the serial-to-parallel deserializer: parameter checks
// and derived sizes.
package serdes_pkg;

   function automatic bit lanes_ok(input int unsigned lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
   endfunction

   function automatic int unsigned beats_f(input int unsigned data_w, input int unsigned lanes);
      return data_w / lanes;
   endfunction

   // Beat counter is never narrower than one bit, even for single-beat words.
   function automatic int unsigned cnt_w_f(input int unsigned beats);
      return (beats < 2) ? 1 : $clog2(beats);
   endfunction

endpackage

// File: rtl/serdes_deser_if.sv
// Serial beat input and parallel word output of the deserializer, bundled
// with the framing error pulse.
interface serdes_deser_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 1
);
   logic [LANES-1:0]  rx_data;
   logic              rx_val;
   logic              rx_sof;
   logic              rx_rdy;
   logic [DATA_W-1:0] tx_data;
   logic              tx_val;
   logic              tx_rdy;
   logic              err_sof;

   modport master (
      output rx_data, rx_val, rx_sof, tx_rdy,
      input  rx_rdy, tx_data, tx_val, err_sof
   );

   modport slave (
      input  rx_data, rx_val, rx_sof, tx_rdy,
      output rx_rdy, tx_data, tx_val, err_sof
   );
endinterface

// File: rtl/serdes_skid_fifo.sv
// Two-entry word buffer between the assembly register and the downstream
// handshake; the head stays put until it is popped.
module serdes_skid_fifo #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/serdes_deser.sv
// Serial-to-parallel deserializer: assembles LANES-bit beats into DATA_W-bit
// words, realigns on rx_sof and buffers two finished words.
module serdes_deser
   import serdes_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LANES     = 1,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic           clk,
   input logic           rst,
   serdes_deser_if.slave bus
);
   localparam int unsigned BEATS = beats_f(DATA_W, LANES);
   localparam int unsigned CW    = cnt_w_f(BEATS);
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   if (!lanes_ok(LANES) || ((DATA_W % LANES) != 0)) begin : g_bad_params
      $error("serdes_deser: LANES must be 1/2/4/8 and divide DATA_W");
   end

   logic [CW-1:0]     cnt;
   logic [CW-1:0]     pos;
   logic              rdy;
   logic              accept;
   logic              completes;
   logic              err_q;
   logic              buf_full;
   logic              buf_empty;
   logic [DATA_W-1:0] asm_q;
   logic [DATA_W-1:0] asm_d;

   // Only a word-completing beat needs buffer space, so stall just that one.
   assign rdy       = !rst && !(buf_full && ((cnt == LAST) || (BEATS == 1)));
   assign accept    = bus.rx_val && rdy;
   assign pos       = bus.rx_sof ? '0 : cnt;
   assign completes = accept && (pos == LAST);

   // In shift mode a fresh rx_sof needs no clearing: the stale bits are
   // shifted out by the time the word completes.
   if (MSB_FIRST) begin : g_msb
      if (BEATS == 1) begin : g_single
         assign asm_d = bus.rx_data;
      end else begin : g_shift
         assign asm_d = {asm_q[DATA_W-LANES-1:0], bus.rx_data};
      end
   end else begin : g_lsb
      always_comb begin
         asm_d = asm_q;
         asm_d[pos*LANES +: LANES] = bus.rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
         asm_q <= '0;
      end else begin
         err_q <= accept && bus.rx_sof && (cnt != '0);
         if (accept) begin
            asm_q <= asm_d;
            cnt   <= completes ? '0 : pos + CW'(1);
         end
      end
   end

   serdes_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (completes),
      .pop   (bus.tx_rdy),
      .din   (asm_d),
      .full  (buf_full),
      .empty (buf_empty),
      .head  (bus.tx_data)
   );

   assign bus.rx_rdy  = rdy;
   assign bus.tx_val  = !buf_empty;
   assign bus.err_sof = err_q;
endmodule

// File: tb/tb_serdes_deser.sv
// Scoreboard bench for serdes_deser: default 1-lane MSB-first instance and a
// 4-lane LSB-first instance.
module tb_serdes_deser;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serdes_deser_if #(.DATA_W(32), .LANES(1)) bus_a ();
   serdes_deser_if #(.DATA_W(32), .LANES(4)) bus_b ();

   serdes_deser #(.DATA_W(32), .LANES(1), .MSB_FIRST(1'b1)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   serdes_deser #(.DATA_W(32), .LANES(4), .MSB_FIRST(1'b0)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          err_cnt_a = 0;
   int          err_cnt_b = 0;
   logic [31:0] exp_a [$];
   logic [31:0] exp_b [$];
   logic        hold_a = 1'b0;
   logic [31:0] hold_data_a = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitors: pop the scoreboard on every handshake, watch tx_data stability.
   always @(negedge clk) begin
      if (rst) begin
         hold_a = 1'b0;
      end else begin
         if (bus_a.err_sof) err_cnt_a++;
         if (hold_a && bus_a.tx_val) chk("a_hold_stable", bus_a.tx_data, hold_data_a);
         if (bus_a.tx_val && bus_a.tx_rdy) begin
            if (exp_a.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL a_unexpected_word: got %h want none", bus_a.tx_data);
            end else begin
               chk("a_word", bus_a.tx_data, exp_a.pop_front());
            end
         end
         hold_a      = bus_a.tx_val && !bus_a.tx_rdy;
         hold_data_a = bus_a.tx_data;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_b.err_sof) err_cnt_b++;
         if (bus_b.tx_val && bus_b.tx_rdy) begin
            if (exp_b.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL b_unexpected_word: got %h want none", bus_b.tx_data);
            end else begin
               chk("b_word", bus_b.tx_data, exp_b.pop_front());
            end
         end
      end
   end

   // Present one beat and return 1 ns after the edge that accepted it.
   task automatic beat_a(input logic d, input logic sof);
      bit ok = 1'b0;
      bus_a.rx_data = d;
      bus_a.rx_sof  = sof;
      bus_a.rx_val  = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus_a.rx_rdy;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL a_beat_timeout: rx_rdy got 0 want 1");
      end
   endtask

   task automatic beat_b(input logic [3:0] d, input logic sof);
      bit ok = 1'b0;
      bus_b.rx_data = d;
      bus_b.rx_sof  = sof;
      bus_b.rx_val  = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus_b.rx_rdy;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL b_beat_timeout: rx_rdy got 0 want 1");
      end
   endtask

   task automatic send_word_a(input logic [31:0] w, input bit first_sof);
      for (int i = 0; i < 32; i++) beat_a(w[31-i], first_sof && (i == 0));
   endtask

   task automatic idle(input int n);
      bus_a.rx_val = 1'b0;
      bus_b.rx_val = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  nb [8];
      logic [31:0] w3;
      nb = '{4'h6, 4'h9, 4'h1, 4'h0, 4'hF, 4'hE, 4'hB, 4'hC};
      w3 = 32'h8000_0001;

      rst = 1'b1;
      bus_a.rx_data = '0; bus_a.rx_val = 1'b0; bus_a.rx_sof = 1'b0; bus_a.tx_rdy = 1'b1;
      bus_b.rx_data = '0; bus_b.rx_val = 1'b0; bus_b.rx_sof = 1'b0; bus_b.tx_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_rx_rdy", 32'(bus_a.rx_rdy), 32'd0);
      chk("rst_a_tx_val", 32'(bus_a.tx_val), 32'd0);
      chk("rst_a_tx_data", bus_a.tx_data, 32'd0);
      chk("rst_a_err_sof", 32'(bus_a.err_sof), 32'd0);
      chk("rst_b_tx_data", bus_b.tx_data, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_a_tx_val", 32'(bus_a.tx_val), 32'd0);
      chk("post_rst_a_rx_rdy", 32'(bus_a.rx_rdy), 32'd1);

      // LSB-first 4-lane word, then a realigned word after 3 stray beats.
      exp_b.push_back(32'hCBEF_0196);
      for (int i = 0; i < 8; i++) beat_b(nb[i], i == 0);
      chk("b_latency_tx_val", 32'(bus_b.tx_val), 32'd1);
      chk("b_latency_tx_data", bus_b.tx_data, 32'hCBEF_0196);
      exp_b.push_back(32'h7654_3210);
      beat_b(4'hA, 1'b1);
      beat_b(4'hB, 1'b0);
      beat_b(4'hC, 1'b0);
      for (int i = 0; i < 8; i++) beat_b(4'(i), i == 0);
      idle(4);
      chk("b_err_sof_pulses", 32'(err_cnt_b), 32'd1);

      // MSB-first word: valid one cycle after the 32nd beat, for one cycle.
      exp_a.push_back(32'hA5C3_0F96);
      send_word_a(32'hA5C3_0F96, 1'b1);
      chk("a_latency_tx_val", 32'(bus_a.tx_val), 32'd1);
      chk("a_latency_tx_data", bus_a.tx_data, 32'hA5C3_0F96);
      bus_a.rx_val = 1'b0;
      @(posedge clk);
      #1;
      chk("a_tx_val_one_cycle", 32'(bus_a.tx_val), 32'd0);
      idle(2);
      chk("a_no_err_yet", 32'(err_cnt_a), 32'd0);

      // 17-beat partial word abandoned by a new rx_sof.
      exp_a.push_back(32'h1234_5678);
      for (int i = 0; i < 17; i++) beat_a(1'b1, i == 0);
      send_word_a(32'h1234_5678, 1'b1);
      idle(4);
      chk("a_err_sof_pulses", 32'(err_cnt_a), 32'd1);

      // Back-pressure: two words buffered, third stalls on its last beat.
      bus_a.tx_rdy = 1'b0;
      exp_a.push_back(32'hDEAD_BEEF);
      exp_a.push_back(32'h0F0F_00FF);
      exp_a.push_back(w3);
      send_word_a(32'hDEAD_BEEF, 1'b1);
      send_word_a(32'h0F0F_00FF, 1'b1);
      for (int i = 0; i < 31; i++) beat_a(w3[31-i], i == 0);
      bus_a.rx_val = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("a_stall_rx_rdy", 32'(bus_a.rx_rdy), 32'd0);
      chk("a_stall_tx_data", bus_a.tx_data, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      bus_a.tx_rdy = 1'b1;
      beat_a(w3[0], 1'b0);
      idle(8);
      chk("a_stall_drained", 32'(exp_a.size()), 32'd0);

      // Reset with a buffered word and a 20-beat partial word discards both.
      bus_a.tx_rdy = 1'b0;
      send_word_a(32'h55AA_33CC, 1'b1);
      for (int i = 0; i < 20; i++) beat_a(1'b1, i == 0);
      bus_a.rx_val = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("a_midrst_rx_rdy", 32'(bus_a.rx_rdy), 32'd0);
      @(posedge clk);
      #1;
      chk("a_midrst_tx_val", 32'(bus_a.tx_val), 32'd0);
      chk("a_midrst_tx_data", bus_a.tx_data, 32'd0);
      rst = 1'b0;
      bus_a.tx_rdy = 1'b1;
      exp_a.push_back(32'h0BAD_F00D);
      send_word_a(32'h0BAD_F00D, 1'b0);
      idle(10);
      chk("a_final_drained", 32'(exp_a.size()), 32'd0);
      chk("b_final_drained", 32'(exp_b.size()), 32'd0);
      chk("a_final_err_count", 32'(err_cnt_a), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/serdes_deser.md
# serdes_deser

Parametrised serial-to-parallel deserializer. It collects `LANES` bits per accepted beat into a `DATA_W`-bit word, with selectable bit order and frame realignment on `rx_sof`. Completed words go out through a 2-entry output buffer with a valid/ready handshake, so the block can stall its serial source instead of losing words. It sits between the line-side bit receiver and the word-oriented datapath.

## Interface
- `DATA_W`, default 32: output word width; must be a multiple of `LANES`.
- `LANES`, default 1: bits accepted per beat; one of 1, 2, 4, 8.
- `MSB_FIRST`, default 1: 1 means the first beat lands in the MSBs; 0 means it lands in the LSBs.
- `clk` in 1: the only clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in `LANES`: serial beat; `rx_data[LANES-1]` is the most significant bit within the beat.
- `rx_val` in 1: beat valid.
- `rx_sof` in 1: the qualified beat is the first beat of a new word.
- `rx_rdy` out 1: block can accept a beat. A beat is accepted when `rx_val && rx_rdy`.
- `tx_data` out `DATA_W`: word at the head of the output buffer.
- `tx_val` out 1: `tx_data` is valid.
- `tx_rdy` in 1: downstream accepts the word. A word is popped when `tx_val && tx_rdy`.
- `err_sof` out 1: one-cycle pulse; an accepted `rx_sof` discarded a partial word.

## Operation
- `BEATS = DATA_W/LANES`.
- Beat counter `cnt` is `max(1, $clog2(BEATS))` bits wide and counts 0..BEATS-1.
- Accepted beat with `rx_sof=1`:
  - the beat is stored as beat 0;
  - `cnt` becomes 1, or the word completes immediately if `BEATS==1`;
  - any partial word is dropped.
- Accepted beat with `rx_sof=0`: stored at position `cnt`, then `cnt` increments.
- Word completion: the beat at position BEATS-1 completes the word. The assembled word is pushed into the output buffer and `cnt` wraps to 0.
- Bit placement:
  - `MSB_FIRST=1`: shift left, new beat enters the LSBs. After `BEATS` beats, beat 0 occupies `[DATA_W-1 -: LANES]`.
  - `MSB_FIRST=0`: beat i is written to `[i*LANES +: LANES]`.
- Bits of a partial word that were never written are undefined internally. They never reach `tx_data` because only complete words are pushed.
- `rx_rdy = !rst && !(buf_full && (cnt==BEATS-1 || BEATS==1))`.
  - Depends only on registered state; there is no combinational path from `rx_val`, `rx_sof` or `tx_rdy`.
  - Non-completing beats are always accepted.
  - When `cnt==BEATS-1` and the buffer is full, a `rx_sof` beat is also stalled.
- Output buffer:
  - 2-entry FIFO; `tx_val` = not empty; `tx_data` = head entry.
  - Push and pop in the same cycle is legal at any occupancy where the push is permitted; occupancy stays unchanged.
  - `tx_data` must hold stable while `tx_val && !tx_rdy`.
- `err_sof` asserts in the cycle after an accepted `rx_sof` beat that found `cnt != 0`.
- `rx_val=0`: state holds; `rx_data` and `rx_sof` are ignored.

## Timing
- Reset values (while `rst` is high and in the first cycle after it):
  - `rx_rdy` = 0 while `rst` is high;
  - `tx_val` = 0;
  - `tx_data` = 0;
  - `err_sof` = 0;
  - `cnt` = 0;
  - buffer empty.
- Reset mid-word or with the buffer occupied discards all data. No word is emitted for a partial word.
- Latency: the completing beat accepted at edge k gives `tx_val=1` in cycle k+1 if the buffer was empty.
- Throughput: one beat per cycle, i.e. one word every `BEATS` cycles, sustained with `tx_rdy=1`.
- Stall: with the buffer full and `tx_rdy=0`, `rx_rdy` drops only when the next beat would complete a word. `rx_rdy` recovers the cycle after a pop.

## Structure
- Package `serdes_pkg`:
  - `LANES` legality check function;
  - `beats_f(DATA_W, LANES)`;
  - counter-width function.
- Sub-module `serdes_skid_fifo`:
  - 2-entry, `DATA_W` wide;
  - ports: push/pop/full/empty/head.
- Top level holds the assembly register, `cnt` and the `err_sof` logic.

## Test plan
- Default params, 32 beats of bits of `0xA5C3_0F96` MSB-first with `tx_rdy=1` -> `tx_data=0xA5C3_0F96`, `tx_val` high for exactly 1 cycle, one cycle after the 32nd beat.
- `LANES=4`, `MSB_FIRST=0`, beats 0x6,0x9,0x1,0x0,0xF,0xE,0xB,0xC -> `tx_data=0xCBEF_0196`.
- `rx_sof` on beat 0, 17 beats, `rx_sof` again, 32 beats of `0x1234_5678` -> `err_sof` pulses once, single word `0x1234_5678`.
- `tx_rdy=0`, three back-to-back words -> two words buffered; `rx_rdy` low at `cnt=31` of word 3. After `tx_rdy=1`, all three words emerge in order with no loss and no duplicates.
- `rst` asserted after 20 beats -> `tx_val=0` and no word emitted; the next 32 beats produce exactly one correct word.
